// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction memory handshake and loads
// the IF/ID pipeline register. A one-entry skid buffer keeps a response that
// arrives while the pipeline is frozen, and branches redirect the fetch PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_adrs,
  output logic        imem_req,
  output logic [31:0] imem_adrs,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   skid_pc;
  logic [XLEN-1:0]   skid_inst;
  logic              outstanding;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   branch_target;
  logic              accept;
  logic [1:0]        unused_branch_lsbs;

  // The low address bits of a redirect target are dropped to keep fetches word aligned.
  assign unused_branch_lsbs = branch_adrs[1:0];
  assign branch_target      = {branch_adrs[XLEN-1:2], 2'b00};
  assign pc_plus4           = pc + XLEN'(4);

  // Request is held high while a response is owed, even if the pipe is frozen.
  assign imem_req  = (state == FETCH) && (!freeze || outstanding);
  assign imem_adrs = pc;

  // A response counts only when requested and not killed by a same-cycle branch.
  assign accept = imem_req && imem_ready && !branch_taken;

  // Fetch FSM, PC, skid buffer, IF/ID register and delivered-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= 1'b0;
      skid_pc     <= '0;
      skid_inst   <= '0;
      if_pc       <= '0;
      if_inst     <= NOP_WORD;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      // Redirect wins over freeze and over any in-flight or arriving response.
      state       <= FETCH;
      pc          <= branch_target;
      outstanding <= 1'b0;
      skid_pc     <= '0;
      skid_inst   <= '0;
      if_inst     <= NOP_WORD;
      if_valid    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            pc          <= pc_plus4;
            outstanding <= 1'b0;
            if (freeze) begin
              // Park the word until the pipeline is released.
              skid_pc   <= pc_plus4;
              skid_inst <= imem_inst;
              state     <= HOLD;
            end else begin
              if_pc       <= pc_plus4;
              if_inst     <= imem_inst;
              if_valid    <= 1'b1;
              fetch_count <= fetch_count + XLEN'(1);
            end
          end else begin
            if (imem_req) begin
              outstanding <= 1'b1;
            end
            if (!freeze) begin
              // No word this cycle: insert a bubble, keep the last PC.
              if_inst  <= NOP_WORD;
              if_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            if_pc       <= skid_pc;
            if_inst     <= skid_inst;
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + XLEN'(1);
            state       <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// freeze/branch/ready traffic, checked against a transaction-level model.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_adrs;
  logic        imem_req;
  logic [31:0] imem_adrs;
  logic [31:0] imem_inst;
  logic        imem_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } entry_t;

  // Model state: fetch address, pending-request flag, parked words, IF/ID image.
  logic [31:0] m_pc;
  bit          m_out;
  entry_t      m_skid[$];
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_if_valid;
  logic [31:0] m_count;

  inst_fetch #(
    .RESET_PC (RST_PC),
    .NOP_WORD (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_adrs  (branch_adrs),
    .imem_req     (imem_req),
    .imem_adrs    (imem_adrs),
    .imem_inst    (imem_inst),
    .imem_ready   (imem_ready),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction ROM contents: a distinct word per address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_inst = rom(imem_adrs);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_ifid(input string tag);
    chk({tag, ".if_pc"},    if_pc,             m_if_pc);
    chk({tag, ".if_inst"},  if_inst,           m_if_inst);
    chk({tag, ".if_valid"}, 32'(if_valid),     32'(m_if_valid));
    chk({tag, ".count"},    fetch_count,       m_count);
    chk({tag, ".adrs"},     imem_adrs,         m_pc);
  endtask

  task automatic model_reset();
    m_pc       = RST_PC;
    m_out      = 1'b0;
    m_skid.delete();
    m_if_pc    = 32'h0;
    m_if_inst  = NOP;
    m_if_valid = 1'b0;
    m_count    = 32'h0;
  endtask

  // One clock cycle with the given inputs; checks request before the edge and IF/ID after.
  task automatic step(input bit fz, input bit br, input logic [31:0] ba, input bit rdy,
                      input string tag);
    bit     exp_req;
    entry_t e;
    freeze       = fz;
    branch_taken = br;
    branch_adrs  = ba;
    imem_ready   = rdy;
    #1;
    exp_req = (m_skid.size() == 0) && (!fz || m_out);
    chk({tag, ".req"}, 32'(imem_req), 32'(exp_req));
    chk({tag, ".adrs_pre"}, imem_adrs, m_pc);
    if (br) begin
      m_pc       = ba & 32'hFFFF_FFFC;
      m_out      = 1'b0;
      m_skid.delete();
      m_if_inst  = NOP;
      m_if_valid = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!fz) begin
        e          = m_skid.pop_front();
        m_if_pc    = e.pc4;
        m_if_inst  = e.inst;
        m_if_valid = 1'b1;
        m_count    = m_count + 1;
      end
    end else if (exp_req && rdy) begin
      e.pc4  = m_pc + 32'd4;
      e.inst = rom(m_pc);
      m_pc   = m_pc + 32'd4;
      m_out  = 1'b0;
      if (fz) begin
        m_skid.push_back(e);
      end else begin
        m_if_pc    = e.pc4;
        m_if_inst  = e.inst;
        m_if_valid = 1'b1;
        m_count    = m_count + 1;
      end
    end else begin
      if (exp_req) m_out = 1'b1;
      if (!fz) begin
        m_if_inst  = NOP;
        m_if_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_ifid(tag);
  endtask

  // Asynchronous reset held across one rising edge.
  task automatic do_reset(input bit fz, input string tag);
    freeze       = fz;
    branch_taken = 1'b0;
    branch_adrs  = 32'h0;
    imem_ready   = 1'b0;
    rst          = 1'b1;
    #1;
    model_reset();
    chk({tag, ".req"}, 32'(imem_req), 32'(!fz));
    check_ifid({tag, ".async"});
    @(posedge clk);
    #1;
    check_ifid({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_adrs  = 32'h0;
    imem_ready   = 1'b0;
    model_reset();

    do_reset(1'b0, "rst0");

    // Single-cycle ROM: one instruction per cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, "stream");
    chk("stream.count3_after3", 32'(m_count >= 3), 32'd1);

    // Two-cycle latency: bubbles alternate with valid words.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, (i % 2) == 1, "lat2");

    // Freeze while outstanding; response lands while frozen and is parked.
    step(1'b0, 1'b0, 32'h0, 1'b0, "frz.issue");
    step(1'b1, 1'b0, 32'h0, 1'b0, "frz.wait");
    step(1'b1, 1'b0, 32'h0, 1'b1, "frz.park");
    step(1'b1, 1'b0, 32'h0, 1'b1, "frz.hold");
    step(1'b0, 1'b0, 32'h0, 1'b1, "frz.release");
    step(1'b0, 1'b0, 32'h0, 1'b1, "frz.resume");
    step(1'b0, 1'b0, 32'h0, 1'b1, "frz.resume2");

    // Branch with freeze: target aligned, bubble, count unchanged.
    step(1'b1, 1'b1, 32'h0000_0092, 1'b1, "br.frz");
    chk("br.frz.target", imem_adrs, 32'h0000_0090);
    step(1'b0, 1'b0, 32'h0, 1'b1, "br.after");

    // Branch with a same-cycle response: the response is dropped.
    step(1'b0, 1'b0, 32'h0, 1'b0, "brr.issue");
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, "brr.kill");
    chk("brr.target", imem_adrs, 32'h0000_0200);
    step(1'b0, 1'b0, 32'h0, 1'b1, "brr.fetch");

    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, "wrap.br");
    step(1'b0, 1'b0, 32'h0, 1'b1, "wrap.fetch");
    chk("wrap.if_pc_zero", if_pc, 32'h0);

    // Reset during an outstanding request drops it.
    step(1'b0, 1'b0, 32'h0, 1'b0, "mid.issue");
    do_reset(1'b1, "rst_mid");
    step(1'b0, 1'b0, 32'h0, 1'b1, "mid.restart");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 4) < 3,
           "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'd0, byte address of the first fetch after reset.
REQ-002 Parameter: NOP_WORD, 32'd0, instruction word driven on if_inst when if_valid is 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 freeze  input  1  hazard stall; while high, the IF/ID outputs hold and no new fetch is issued.
REQ-006 branch_taken  input  1  redirect request from EX, one-cycle pulse.
REQ-007 branch_adrs  input  32  redirect target byte address; bits [1:0] are ignored and treated as 00.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_adrs  output  32  instruction memory byte address (word aligned).
REQ-010 imem_inst  input  32  instruction word from memory, valid when imem_ready is high.
REQ-011 imem_ready  input  1  response strobe; when tied high, the combinational instruction ROM answers in the same cycle.
REQ-012 if_pc  output  32  IF/ID register: address of the fetched instruction + 4.
REQ-013 if_inst  output  32  IF/ID register: fetched instruction.
REQ-014 if_valid  output  1  IF/ID register: if_inst is real, not a bubble.
REQ-015 fetch_count  output  32  count of instructions delivered into IF/ID.

Function
REQ-016 State: pc (32-bit), FSM {FETCH, HOLD}, one-entry skid buffer (instruction word + pc+4), outstanding flag.
REQ-017 imem_adrs SHALL equal pc at all times; pc changes only on an accepted response or on a branch.
REQ-018 FETCH: imem_req = !freeze OR outstanding; HOLD: imem_req = 0.
REQ-019 Handshake: once imem_req is high, imem_req and imem_adrs stay stable until imem_ready is sampled high, unless a branch aborts the request; imem_ready while imem_req is low is ignored.
REQ-020 outstanding is set when imem_req=1 and imem_ready=0; it is cleared on an accepted response or on a branch.
REQ-021 Accepted response (FETCH, imem_req=1, imem_ready=1, no branch): pc <= pc+4 (mod 2^32).
- If freeze=0: IF/ID <= {pc+4, imem_inst, 1}.
- If freeze=1: skid <= {pc+4, imem_inst}; FSM -> HOLD; IF/ID holds.
REQ-022 FETCH, no accepted response, freeze=0: IF/ID <= {IF/ID pc unchanged, NOP_WORD, 0} (bubble).
REQ-023 freeze=1 with no branch: IF/ID holds its value.
REQ-024 HOLD: with freeze=1, hold; with freeze=0, IF/ID <= {skid, 1} and FSM -> FETCH. The next fetch is issued in the following cycle.
REQ-025 branch_taken=1 has priority over everything, including freeze, in either state:
- pc <= {branch_adrs[31:2],2'b00}; FSM -> FETCH; skid and outstanding are discarded.
- IF/ID <= {if_pc, NOP_WORD, 0}.
- A response arriving in the same cycle is discarded and not counted.
REQ-026 fetch_count increments by 1 on each IF/ID load with if_valid=1, wrapping at 2^32; bubbles and discarded responses are not counted.
REQ-027 Throughput with imem_ready tied high and freeze=0: one instruction per cycle; if_inst in cycle n+1 equals the ROM word at the address presented in cycle n.

Reset
REQ-028 While rst is high, asynchronously: pc=RESET_PC, FSM=FETCH, outstanding=0, skid cleared, if_pc=0, if_inst=NOP_WORD, if_valid=0, fetch_count=0; imem_req follows REQ-018 (=1 when freeze=0).
REQ-029 Reset asserted mid-request drops the outstanding request. The first edge after rst deasserts starts fetching at RESET_PC.

Verification
REQ-030 Reset, imem_ready=1, freeze=0 for 4 cycles -> imem_adrs 0,4,8,12; if_pc 4,8,12 with if_valid=1; fetch_count=3.
REQ-031 2-cycle memory latency (ready in every second requested cycle) -> a bubble alternates with each valid instruction, and imem_adrs stays stable across each wait.
REQ-032 freeze raised while a request is outstanding, ready arrives while frozen -> FSM goes to HOLD and imem_req=0; after freeze drops, if_inst equals the buffered word and fetch continues at +4.
REQ-033 branch_taken with branch_adrs=0x92 and freeze=1 in the same cycle -> next cycle imem_adrs=0x90, if_valid=0, and fetch_count unchanged.
REQ-034 Branch in the same cycle as imem_ready=1 -> the response is discarded; the next request goes to the target address.
REQ-035 pc=0xFFFFFFFC fetched -> pc wraps to 0 and if_pc=0.
